scu_timer_unit: RTL and testbench
=================================

Name: scu_timer_unit

Overview:
- Implements the two SCU timers, Timer 0 and Timer 1, and holds the T0C, T1S and T1MD registers that the CPU writes.
- Timer 0 counts HBlank-in events within a frame. Timer 1 counts down a pixel-rate prescaled interval within each line.
- Produces single-cycle T0I/T1I interrupt-request pulses, which the SCU interrupt status logic sets into IST bits 3 and 4.
- Sits between the SCU register decode and the interrupt controller.

Parameters:
- T1_DIV, 4, number of CE cycles per Timer 1 decrement tick (must be 1..256).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable; gates all counter state except register writes
- HBLANK  in  1  VDP2 HBlank level; rising edge = HBlank-in
- VBLANK  in  1  VDP2 VBlank level; falling edge = VBlank-out
- DI  in  32  register write data
- T0C_WR  in  1  write strobe, T0C (DI[9:0])
- T1S_WR  in  1  write strobe, T1S (DI[8:0])
- T1MD_WR  in  1  write strobe, T1MD (DI[8]=MD, DI[0]=ENB)
- T0_IRQ  out  1  Timer 0 compare-match pulse
- T1_IRQ  out  1  Timer 1 underflow pulse

Behaviour:
- Reset values:
  - T0C=0, T1S=0, MD=0, ENB=0.
  - t0_cnt=0, t1_cnt=0, prescaler=0, t1_armed=0, line_match=0.
  - Edge-detect registers=0; T0_IRQ=0, T1_IRQ=0.
  - Reset mid-operation aborts everything, and no pulse is emitted on the following cycle.
- Register writes:
  - Take effect on the CLK edge where the strobe is high, independent of CE.
  - Bits outside the write masks are ignored.
  - A write lands in the register only. It does not touch t0_cnt, t1_cnt or line_match.
- Edge detection:
  - hb_prev and vb_prev are registered only when CE=1.
  - hbi = CE & HBLANK & ~hb_prev.
  - vbo = CE & ~VBLANK & vb_prev.
- Timer 0 (10-bit t0_cnt):
  - vbo: t0_cnt <= 0.
  - Otherwise hbi: t0_cnt <= t0_cnt+1, wrapping 1023->0.
  - vbo and hbi in the same cycle: vbo wins and the result is 0.
  - On any cycle where t0_cnt is updated, the new value is compared with T0C:
    - Match sets line_match=1.
    - Match with ENB=1 gives T0_IRQ=1 on the next cycle, for exactly 1 cycle.
  - line_match is cleared on any hbi or vbo that does not produce a match.
- Timer 1 (9-bit t1_cnt):
  - On hbi: t1_cnt <= T1S, prescaler <= 0, t1_armed <= 1.
  - Otherwise, when CE=1, the prescaler increments. At T1_DIV-1 it wraps to 0 and issues a tick.
  - On a tick with t1_armed=1:
    - t1_cnt>1: decrement.
    - t1_cnt is 1 or 0: set t1_cnt=0, t1_armed=0 and fire.
    - T1S=0 therefore fires on the first tick after reload.
  - Fire with ENB=1 and (MD=0 or line_match=1) gives T1_IRQ=1 on the next cycle, for 1 cycle.
  - At most one T1 fire per line; it rearms only on the next hbi.
  - ENB=0 suppresses both IRQ outputs, but the counters keep running.
- IRQ outputs are registered, with latency 1 cycle from the triggering edge. T0_IRQ and T1_IRQ may pulse in the same cycle.

Optional Feature:
- Macro: SCU_TIMER_READBACK_EN.
- When defined:
  - Adds output T0_CNT_DBG[9:0], equal to t0_cnt.
  - Adds output T1_CNT_DBG[8:0], equal to t1_cnt.
  - Both are registered values, reset to 0.
- When undefined, these ports and any associated logic are absent. IRQ behaviour is identical in both builds.

Test Plan:
- Timer 0 compare: RST, write T0C=3 and T1MD=0x001, CE=1, VBLANK 1->0, then 3 HBLANK rising edges -> T0_IRQ pulses once, 1 cycle after the third edge; no pulse after edges 1, 2 or 4.
- Simultaneous edges: T0C=0, ENB=1, vbo and hbi in the same cycle -> t0_cnt=0 and one T0_IRQ pulse.
- Timer 1, MD=0: T1S=5, T1_DIV=4, ENB=1, CE=1 -> T1_IRQ exactly 5×4 CE cycles after each hbi (±1 for register latency fixed by design), once per line.
- Timer 1, MD=1: T0C=2, T1S=1 -> T1_IRQ only on line 2 after vbo; none on lines 1 and 3.
- T1S=0 and ENB gating: T1S=0 -> T1_IRQ on the first tick after hbi. Then write T1MD=0 -> no IRQs, while the SCU_TIMER_READBACK_EN build still shows t0_cnt advancing.
- Reset mid-count: assert RST while t1_cnt=3 -> next cycle all counters 0, no T1_IRQ until a new hbi plus the full interval.

Source files
------------

// File: rtl/scu_timer_unit_if.sv
// ---------------------------------------------------------------------------
// scu_timer_unit_if -- register-write / interrupt-request bundle between the
// SCU register decode, the timer unit and the interrupt status logic.
//
//   DI       32  register write data (decode -> timer)
//   T0C_WR    1  T0C write strobe, data in DI[9:0]
//   T1S_WR    1  T1S write strobe, data in DI[8:0]
//   T1MD_WR   1  T1MD write strobe, DI[8]=MD, DI[0]=ENB
//   T0_IRQ    1  Timer 0 compare-match pulse (timer -> IST bit 3)
//   T1_IRQ    1  Timer 1 underflow pulse     (timer -> IST bit 4)
//
// master: SCU side (drives writes, sees IRQs); slave: the timer unit.
// ---------------------------------------------------------------------------
interface scu_timer_unit_if;
  logic [31:0] DI;
  logic        T0C_WR;
  logic        T1S_WR;
  logic        T1MD_WR;
  logic        T0_IRQ;
  logic        T1_IRQ;

  modport master (
    output DI, T0C_WR, T1S_WR, T1MD_WR,
    input  T0_IRQ, T1_IRQ
  );

  modport slave (
    input  DI, T0C_WR, T1S_WR, T1MD_WR,
    output T0_IRQ, T1_IRQ
  );
endinterface

// File: rtl/scu_timer_unit.sv
// ---------------------------------------------------------------------------
// scu_timer_unit -- SCU Timer 0 / Timer 1.
//
// Timer 0 counts HBlank-in events since the last VBlank-out and raises T0_IRQ
// when the count equals T0C. Timer 1 is reloaded from T1S at every HBlank-in
// and counts down once per T1_DIV CE cycles; on reaching the bottom it raises
// T1_IRQ (optionally only on the line Timer 0 matched, MD=1). Both IRQs are
// single-cycle registered pulses, gated by ENB.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   CE             clock enable for all counter / edge-detect state
//   HBLANK, VBLANK VDP2 blanking levels
//   bus            scu_timer_unit_if.slave (register writes, IRQ pulses)
//   T0_CNT_DBG     t0_cnt readback  (only with SCU_TIMER_READBACK_EN)
//   T1_CNT_DBG     t1_cnt readback  (only with SCU_TIMER_READBACK_EN)
//
// Parameter T1_DIV: CE cycles per Timer 1 tick, 1..256.
// Optional macro SCU_TIMER_READBACK_EN adds the two debug counter outputs.
// ---------------------------------------------------------------------------
module scu_timer_unit #(
  parameter int T1_DIV = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic                   HBLANK,
  input  logic                   VBLANK,
`ifdef SCU_TIMER_READBACK_EN
  output logic [9:0]             T0_CNT_DBG,
  output logic [8:0]             T1_CNT_DBG,
`endif
  scu_timer_unit_if.slave        bus
);

  if (T1_DIV < 1 || T1_DIV > 256) begin : g_bad_div
    $error("scu_timer_unit: T1_DIV must be in 1..256");
  end

  // Prescaler only needs to reach T1_DIV-1; keep at least one bit so the
  // T1_DIV=1 build (tick every CE cycle) still has a legal vector.
  localparam int PW = (T1_DIV > 1) ? $clog2(T1_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(T1_DIV - 1);

  // CPU-visible registers
  logic [9:0]    t0c_q,  t0c_d;
  logic [8:0]    t1s_q,  t1s_d;
  logic          md_q,   md_d;
  logic          enb_q,  enb_d;

  // Edge detect
  logic          hb_prev_q, hb_prev_d;
  logic          vb_prev_q, vb_prev_d;
  logic          hbi, vbo;

  // Timer 0
  logic [9:0]    t0_cnt_q, t0_cnt_d;
  logic          line_match_q, line_match_d;
  logic          t0_upd, t0_match;

  // Timer 1
  logic [8:0]    t1_cnt_q, t1_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          t1_armed_q, t1_armed_d;
  logic          t1_tick, t1_fire;

  // IRQ pulse registers
  logic          t0_irq_q, t0_irq_d;
  logic          t1_irq_q, t1_irq_d;

  logic          unused_di;
  assign unused_di = ^bus.DI[31:10];

  always_comb begin
    // ---- register writes: independent of CE, masked to their fields
    t0c_d = bus.T0C_WR  ? bus.DI[9:0] : t0c_q;
    t1s_d = bus.T1S_WR  ? bus.DI[8:0] : t1s_q;
    md_d  = bus.T1MD_WR ? bus.DI[8]   : md_q;
    enb_d = bus.T1MD_WR ? bus.DI[0]   : enb_q;

    // ---- edge detect; history only advances on enabled cycles
    hb_prev_d = CE ? HBLANK : hb_prev_q;
    vb_prev_d = CE ? VBLANK : vb_prev_q;
    hbi       = CE &  HBLANK & ~hb_prev_q;
    vbo       = CE & ~VBLANK &  vb_prev_q;

    // ---- Timer 0: vbo has priority over hbi in the same cycle
    t0_upd   = vbo | hbi;
    t0_cnt_d = t0_cnt_q;
    if (vbo)      t0_cnt_d = '0;
    else if (hbi) t0_cnt_d = t0_cnt_q + 10'd1;

    // Compare uses the freshly updated count; line_match tracks the result
    // of the most recent update (set on match, cleared otherwise).
    t0_match     = t0_upd & (t0_cnt_d == t0c_q);
    line_match_d = t0_upd ? t0_match : line_match_q;
    t0_irq_d     = t0_match & enb_q;

    // ---- Timer 1
    t1_cnt_d   = t1_cnt_q;
    presc_d    = presc_q;
    t1_armed_d = t1_armed_q;
    t1_tick    = 1'b0;
    t1_fire    = 1'b0;
    if (hbi) begin
      // New line: reload and restart the tick phase from zero.
      t1_cnt_d   = t1s_q;
      presc_d    = '0;
      t1_armed_d = 1'b1;
    end else if (CE) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        t1_tick = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (t1_tick && t1_armed_q) begin
        if (t1_cnt_q > 9'd1) begin
          t1_cnt_d = t1_cnt_q - 9'd1;
        end else begin
          // 1 or 0 both terminate; disarm so only one fire per line.
          t1_cnt_d   = '0;
          t1_armed_d = 1'b0;
          t1_fire    = 1'b1;
        end
      end
    end
    // A fire never coincides with hbi, so line_match_q is the current
    // line's Timer 0 compare result.
    t1_irq_d = t1_fire & enb_q & (~md_q | line_match_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      t0c_q        <= '0;
      t1s_q        <= '0;
      md_q         <= 1'b0;
      enb_q        <= 1'b0;
      hb_prev_q    <= 1'b0;
      vb_prev_q    <= 1'b0;
      t0_cnt_q     <= '0;
      line_match_q <= 1'b0;
      t1_cnt_q     <= '0;
      presc_q      <= '0;
      t1_armed_q   <= 1'b0;
      t0_irq_q     <= 1'b0;
      t1_irq_q     <= 1'b0;
    end else begin
      t0c_q        <= t0c_d;
      t1s_q        <= t1s_d;
      md_q         <= md_d;
      enb_q        <= enb_d;
      hb_prev_q    <= hb_prev_d;
      vb_prev_q    <= vb_prev_d;
      t0_cnt_q     <= t0_cnt_d;
      line_match_q <= line_match_d;
      t1_cnt_q     <= t1_cnt_d;
      presc_q      <= presc_d;
      t1_armed_q   <= t1_armed_d;
      t0_irq_q     <= t0_irq_d;
      t1_irq_q     <= t1_irq_d;
    end
  end

  assign bus.T0_IRQ = t0_irq_q;
  assign bus.T1_IRQ = t1_irq_q;

`ifdef SCU_TIMER_READBACK_EN
  assign T0_CNT_DBG = t0_cnt_q;
  assign T1_CNT_DBG = t1_cnt_q;
`endif

endmodule

// File: tb/tb_scu_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_scu_timer_unit -- directed scoreboard bench for scu_timer_unit
// (T1_DIV=4). Stimulus pushes the expected IRQ cycle into q0/q1; monitors
// pop and compare whenever an IRQ pulse appears, and flag missed pulses.
// cyc = number of rising CLK edges so far. HBLANK raised after edge c is
// seen as hbi at edge c+1, so T0_IRQ is visible after edge c+1 and T1_IRQ
// after edge c+1+4*max(T1S,1).
// ---------------------------------------------------------------------------
module tb_scu_timer_unit;
  localparam int LINE = 32;

  logic CLK = 1'b0;
  logic RST, CE, HBLANK, VBLANK;
  scu_timer_unit_if bus();
`ifdef SCU_TIMER_READBACK_EN
  logic [9:0] t0_dbg;
  logic [8:0] t1_dbg;
`endif

  scu_timer_unit #(.T1_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .HBLANK(HBLANK), .VBLANK(VBLANK),
`ifdef SCU_TIMER_READBACK_EN
    .T0_CNT_DBG(t0_dbg), .T1_CNT_DBG(t1_dbg),
`endif
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int q0[$];
  int q1[$];
  int total = 0;
  int bad   = 0;

  // ---- monitors
  always @(negedge CLK) begin
    while (q0.size() > 0 && q0[0] < cyc) begin
      total++; bad++;
      $display("FAIL t0_irq missed: expected pulse at cycle %0d, none (now %0d)", q0[0], cyc);
      void'(q0.pop_front());
    end
    if (bus.T0_IRQ) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL t0_irq unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        int e;
        e = q0.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL t0_irq timing: pulse at cycle %0d, required %0d", cyc, e);
        end
      end
    end
  end

  always @(negedge CLK) begin
    while (q1.size() > 0 && q1[0] < cyc) begin
      total++; bad++;
      $display("FAIL t1_irq missed: expected pulse at cycle %0d, none (now %0d)", q1[0], cyc);
      void'(q1.pop_front());
    end
    if (bus.T1_IRQ) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL t1_irq unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        int e;
        e = q1.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL t1_irq timing: pulse at cycle %0d, required %0d", cyc, e);
        end
      end
    end
  end

  // ---- helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // which: 0=T0C, 1=T1S, 2=T1MD
  task automatic wr(input int which, input logic [31:0] d);
    bus.DI = d;
    case (which)
      0: bus.T0C_WR  = 1'b1;
      1: bus.T1S_WR  = 1'b1;
      default: bus.T1MD_WR = 1'b1;
    endcase
    tick(1);
    bus.T0C_WR = 1'b0; bus.T1S_WR = 1'b0; bus.T1MD_WR = 1'b0;
  endtask

  // One line: HBLANK rising (optionally with VBLANK falling in the same cycle)
  task automatic do_line(input bit vb_drop, input bit e0, input bit e1, input int t1n);
    int c;
    c = cyc;
    HBLANK = 1'b1;
    if (vb_drop) VBLANK = 1'b0;
    if (e0) q0.push_back(c + 1);
    if (e1) q1.push_back(c + 1 + 4 * t1n);
    tick(3);
    HBLANK = 1'b0;
    tick(LINE - 3);
  endtask

  task automatic vb_out();
    VBLANK = 1'b0;
    tick(4);
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; HBLANK = 1'b0; VBLANK = 1'b1;
    bus.DI = '0; bus.T0C_WR = 1'b0; bus.T1S_WR = 1'b0; bus.T1MD_WR = 1'b0;
    tick(3);
    check("reset t0_irq", int'(bus.T0_IRQ), 0);
    check("reset t1_irq", int'(bus.T1_IRQ), 0);
`ifdef SCU_TIMER_READBACK_EN
    check("reset t0_cnt", int'(t0_dbg), 0);
    check("reset t1_cnt", int'(t1_dbg), 0);
`endif
    RST = 1'b0;
    tick(2);

    // Timer 0 compare at line 3; T1S=0 so Timer 1 fires 4 cycles into each line
    wr(0, 32'hFFFF_FC03);          // upper bits must be ignored -> T0C=3
    wr(2, 32'h0000_0001);          // ENB=1, MD=0
    vb_out();
    do_line(0, 0, 1, 1);
    do_line(0, 0, 1, 1);
    do_line(0, 1, 1, 1);
    do_line(0, 0, 1, 1);

    // vbo and hbi together: count goes to 0, matches T0C=0
    wr(0, 32'h0);
    VBLANK = 1'b1; tick(2);
    do_line(1, 1, 1, 1);

    // Timer 1, MD=0, T1S=5: fire 20 cycles after each hbi
    wr(0, 32'd500);
    wr(1, 32'd5);
    do_line(0, 0, 1, 5);
    do_line(0, 0, 1, 5);

    // Timer 1, MD=1, T0C=2, T1S=1: only line 2 after vbo
    wr(0, 32'd2);
    wr(1, 32'd1);
    wr(2, 32'h0000_0101);
    VBLANK = 1'b1; tick(2);
    vb_out();
    do_line(0, 0, 0, 1);
    do_line(0, 1, 1, 1);
    do_line(0, 0, 0, 1);

    // T1S=0 fires on first tick; then ENB=0 silences both IRQs
    wr(2, 32'h0000_0001);
    wr(1, 32'd0);
    do_line(0, 0, 1, 1);           // t0_cnt=4
    wr(2, 32'h0);
    do_line(0, 0, 0, 1);           // t0_cnt=5
`ifdef SCU_TIMER_READBACK_EN
    check("enb0 t0_cnt line a", int'(t0_dbg), 5);
`endif
    do_line(0, 0, 0, 1);           // t0_cnt=6
`ifdef SCU_TIMER_READBACK_EN
    check("enb0 t0_cnt line b", int'(t0_dbg), 6);
`endif

    // Reset while t1_cnt=3
    wr(2, 32'h0000_0001);
    wr(1, 32'd5);
    begin
      HBLANK = 1'b1;
      tick(3);
      HBLANK = 1'b0;
      tick(6);                     // reload at +1, ticks at +5 (4), +9 (3)
`ifdef SCU_TIMER_READBACK_EN
      check("pre-reset t1_cnt", int'(t1_dbg), 3);
`endif
      RST = 1'b1;
      tick(1);
      check("post-reset t1_irq", int'(bus.T1_IRQ), 0);
`ifdef SCU_TIMER_READBACK_EN
      check("post-reset t0_cnt", int'(t0_dbg), 0);
      check("post-reset t1_cnt", int'(t1_dbg), 0);
`endif
      RST = 1'b0;
      tick(LINE);
    end
    wr(2, 32'h0000_0001);          // registers were cleared by reset
    wr(1, 32'd5);
    do_line(0, 0, 1, 5);
    tick(4);

    check("t0 queue drained", q0.size(), 0);
    check("t1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
